uart_tx_fifo: RTL

Buffered UART transmitter: the serial source that drives the `Rx` input of the UART receiver → processor → address decoder chain. Bytes written into a small FIFO are serialised as 8N1 frames, or 8-bit frames with an optional parity bit. The bit timing and frame format are identical to what the receiver samples. It is used as the on-chip stimulus/echo source and as the transmit half of the host link.

---
 rtl/uart_tx_fifo.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
// uart_tx_fifo
// Buffered UART transmitter. Bytes pushed into a small FIFO are sent LSB
// first as start + 8 data + optional parity + stop. Each bit lasts
// CLKS_PER_BIT clocks. When the FIFO is not empty at the end of a stop bit,
// the next frame follows with no idle gap.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   wr_en       push request; accepted only while not full
//   wr_data     byte to push
//   parity_en   insert a parity bit after D7 (latched at frame start)
//   Tx          registered serial output, idle high
//   full/empty  FIFO status
//   count       FIFO occupancy, 0..DEPTH
//   busy        a frame is on the line
//   overflow    sticky, set by a write attempted while full
//   o_dbg_state current FSM state, for debug and checkers
//
// Write handshake: a push happens on a rising edge where wr_en=1 and full=0.
// A write while full is dropped and sets overflow. There is no ready/back-
// pressure beyond full. full is taken before any pop in the same cycle, so a
// write is never accepted into the slot that a simultaneous pop frees.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 32,
    parameter int DEPTH        = 4,
    parameter int PARITY_ODD   = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     parity_en,
    output logic                     Tx,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy,
    output logic                     overflow,
    output logic [2:0]               o_dbg_state
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam int BCW   = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [BCW-1:0]   BIT_LAST = BCW'(CLKS_PER_BIT - 1);
    localparam logic [BCW-1:0]   BCNT_ONE = BCW'(1);
    localparam logic             PAR_ODD  = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [7:0]       r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic [BCW-1:0]   r_bit_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_par_bit;
    logic             r_par_en;
    logic             r_tx;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_tc;
    logic             w_tx_next;
    logic [7:0]       w_head;

    assign w_full  = (r_count == CNT_FULL);
    assign w_empty = (r_count == '0);
    assign w_push  = wr_en && !w_full;
    assign w_tc    = (r_bit_cnt == BIT_LAST);
    assign w_head  = r_mem[r_rd_ptr];

    assign Tx          = r_tx;
    assign full        = w_full;
    assign empty       = w_empty;
    assign count       = r_count;
    assign busy        = (r_state != S_IDLE);
    assign overflow    = r_overflow;
    assign o_dbg_state = r_state;

    // Next state, pop decision and the line level for the coming cycle.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_tx_next    = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_state_next = S_START;
                    w_pop        = 1'b1;
                end
            end
            S_START: begin
                if (w_tc) w_state_next = S_DATA;
            end
            S_DATA: begin
                if (w_tc && (r_bit_idx == 3'd7))
                    w_state_next = r_par_en ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (w_tc) w_state_next = S_STOP;
            end
            S_STOP: begin
                if (w_tc) begin
                    if (!w_empty) begin
                        w_state_next = S_START;
                        w_pop        = 1'b1;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase

        // r_shift[0] is the bit currently on the line; at a data-bit boundary
        // the next bit is r_shift[1] because the shift lands on the same edge.
        case (w_state_next)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = ((r_state == S_DATA) && w_tc) ? r_shift[1] : r_shift[0];
            S_PARITY: w_tx_next = r_par_bit;
            default:  w_tx_next = 1'b1;
        endcase
    end

    // FIFO storage needs no reset: reset clears the pointers and the count.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_bit_cnt  <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_par_bit  <= 1'b0;
            r_par_en   <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_tx    <= w_tx_next;

            if ((r_state == S_IDLE) || w_tc) r_bit_cnt <= '0;
            else                             r_bit_cnt <= r_bit_cnt + BCNT_ONE;

            if (w_pop) begin
                r_shift   <= w_head;
                r_par_bit <= (^w_head) ^ PAR_ODD;
                r_par_en  <= parity_en;
                r_bit_idx <= '0;
                r_rd_ptr  <= r_rd_ptr + PTR_ONE;
            end else if ((r_state == S_DATA) && w_tc) begin
                r_shift   <= {1'b0, r_shift[7:1]};
                r_bit_idx <= r_bit_idx + 3'd1;
            end

            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;

            if (wr_en && w_full) r_overflow <= 1'b1;

            if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
            else if (w_pop && !w_push) r_count <= r_count - CNT_ONE;
        end
    end

endmodule
